// File: rtl/lane_accum_pkg.sv
// Shared definitions for the multi-lane frame accumulator: reduction modes,
// default parameters and a helper that extracts one lane from a packed bus.
package lane_accum_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DEF_LANES     = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_FRAME_LEN = 4;

  // Widest packed input bus and widest single lane the helper can serve.
  localparam int BUS_MAX   = 1024;
  localparam int SLICE_MAX = 64;

  // Returns the low SLICE_MAX bits starting at lane*width; the caller
  // truncates to its own lane width.
  function automatic logic [SLICE_MAX-1:0] lane_slice(
    input logic [BUS_MAX-1:0] bus,
    input int                 lane,
    input int                 width
  );
    return SLICE_MAX'(bus >> (lane * width));
  endfunction

endpackage

// File: rtl/lane_accum_if.sv
// Input and output channels of the frame accumulator.
// Handshake: a beat moves on a rising edge where vld=1 and busy=0; the
// producer holds vld/data until that edge, busy depends only on registered state.
interface lane_accum_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);

  logic                    din_busy;
  logic                    din_vld;
  logic [LANES*DATA_W-1:0] din_data;
  logic [1:0]              din_mode;

  logic                    dout_busy;
  logic                    dout_vld;
  logic [LANES*ACC_W-1:0]  dout_data;
  logic [LANES-1:0]        dout_ovf;

  modport master (
    input  din_busy,
    output din_vld,
    output din_data,
    output din_mode,
    output dout_busy,
    input  dout_vld,
    input  dout_data,
    input  dout_ovf
  );

  modport slave (
    output din_busy,
    input  din_vld,
    input  din_data,
    input  din_mode,
    input  dout_busy,
    output dout_vld,
    output dout_data,
    output dout_ovf
  );

endinterface

// File: rtl/lane_accum_dut_lane.sv
// One lane of the accumulator: holds the running reduction and sum-wrap flag,
// and presents the value that includes the beat currently being accepted.
module lane_accum_lane
  import lane_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_accept,
  input  logic              i_first,
  input  mode_e             i_mode,
  input  logic [DATA_W-1:0] i_sample,
  output logic [ACC_W-1:0]  o_next_acc,
  output logic              o_next_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_next_ovf;

  assign w_ext = ACC_W'(i_sample);
  assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

  always_comb begin
    w_next_acc = r_acc;
    w_next_ovf = r_ovf;
    if (i_first) begin
      w_next_acc = w_ext;
      w_next_ovf = 1'b0;
    end else begin
      case (i_mode)
        MODE_MAX: w_next_acc = (w_ext > r_acc) ? w_ext : r_acc;
        MODE_MIN: w_next_acc = (w_ext < r_acc) ? w_ext : r_acc;
        // Reserved encoding reduces like a sum.
        default: begin
          w_next_acc = w_sum[ACC_W-1:0];
          w_next_ovf = r_ovf | w_sum[ACC_W];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_accept) begin
      r_acc <= w_next_acc;
      r_ovf <= w_next_ovf;
    end
  end

  assign o_next_acc = w_next_acc;
  assign o_next_ovf = w_next_ovf;

endmodule

// File: rtl/lane_accum_dut.sv
// Multi-lane frame accumulator: reduces FRAME_LEN beats per lane (sum/max/min)
// and parks the packed result in a one-deep output register.
module lane_accum_dut
  import lane_accum_pkg::*;
#(
  parameter int LANES     = DEF_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  lane_accum_if.slave      bus,
  output logic [CNT_W-1:0] o_dbg_cnt,
  output logic             o_dbg_out_full
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_full;
  mode_e                  r_mode;
  logic [LANES*ACC_W-1:0] r_dout_data;
  logic [LANES-1:0]       r_dout_ovf;

  logic                   w_first;
  logic                   w_last;
  logic                   w_busy;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_full_nxt;
  logic                   w_load_out;
  logic [LANES*ACC_W-1:0] w_next_data;
  logic [LANES-1:0]       w_next_ovf;

  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == LAST_BEAT);
  // Only a final beat can stall, and only while the previous result waits.
  assign w_busy     = w_last && r_out_full;
  assign w_in_fire  = bus.din_vld && !w_busy;
  assign w_out_fire = r_out_full && !bus.dout_busy;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_full_nxt = r_out_full;
    w_load_out = 1'b0;
    if (w_out_fire) begin
      w_full_nxt = 1'b0;
    end
    if (w_in_fire) begin
      if (w_last) begin
        w_cnt_nxt  = '0;
        w_full_nxt = 1'b1;
        w_load_out = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_out_full <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_out_full <= w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode <= MODE_SUM;
    end else if (w_in_fire && w_first) begin
      r_mode <= mode_e'(bus.din_mode);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_W-1:0] w_sample;

    assign w_sample = DATA_W'(lane_slice(BUS_MAX'(bus.din_data), gi, DATA_W));

    lane_accum_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_accept   (w_in_fire),
      .i_first    (w_first),
      .i_mode     (r_mode),
      .i_sample   (w_sample),
      .o_next_acc (w_next_data[gi*ACC_W +: ACC_W]),
      .o_next_ovf (w_next_ovf[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout_data <= '0;
      r_dout_ovf  <= '0;
    end else if (w_load_out) begin
      r_dout_data <= w_next_data;
      r_dout_ovf  <= w_next_ovf;
    end
  end

  assign bus.din_busy  = w_busy;
  assign bus.dout_vld  = r_out_full;
  assign bus.dout_data = r_dout_data;
  assign bus.dout_ovf  = r_dout_ovf;

  assign o_dbg_cnt      = r_cnt;
  assign o_dbg_out_full = r_out_full;

  a_hold_while_stalled : assert property (@(posedge clk) disable iff (!rst)
    (r_out_full && bus.dout_busy) |=> (r_out_full && $stable(r_dout_data) && $stable(r_dout_ovf)));

  a_no_drain_and_load : assert property (@(posedge clk) disable iff (!rst)
    !(w_out_fire && w_load_out));

endmodule

// File: tb/tb_lane_accum_dut.sv
// Bench for lane_accum_dut: three configurations (default, 8-bit sums, single-beat frames)
// driven with directed and random frames against a frame-level reference model.
module tb_lane_accum_dut;
  import lane_accum_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  lane_accum_if #(.LANES(8), .DATA_W(8), .ACC_W(32)) a_if ();
  lane_accum_if #(.LANES(2), .DATA_W(8), .ACC_W(8))  b_if ();
  lane_accum_if #(.LANES(4), .DATA_W(8), .ACC_W(16)) c_if ();

  logic [1:0] a_dbg_cnt;
  logic       a_dbg_full;
  logic [1:0] b_dbg_cnt;
  logic       b_dbg_full;
  logic [0:0] c_dbg_cnt;
  logic       c_dbg_full;

  logic a_busy, a_rand_en, a_rand_busy, b_busy, c_busy;
  assign a_if.dout_busy = a_rand_en ? a_rand_busy : a_busy;
  assign b_if.dout_busy = b_busy;
  assign c_if.dout_busy = c_busy;

  lane_accum_dut #(.LANES(8), .DATA_W(8), .ACC_W(32), .FRAME_LEN(4)) u_dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .o_dbg_cnt(a_dbg_cnt), .o_dbg_out_full(a_dbg_full));
  lane_accum_dut #(.LANES(2), .DATA_W(8), .ACC_W(8), .FRAME_LEN(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .o_dbg_cnt(b_dbg_cnt), .o_dbg_out_full(b_dbg_full));
  lane_accum_dut #(.LANES(4), .DATA_W(8), .ACC_W(16), .FRAME_LEN(1)) u_dut_c (
    .clk(clk), .rst(rst), .bus(c_if), .o_dbg_cnt(c_dbg_cnt), .o_dbg_out_full(c_dbg_full));

  always @(posedge clk) begin
    #1 a_rand_busy = ($urandom_range(0, 3) == 0);
  end

  // ---------------- reference model ----------------
  logic [255:0] a_qd[$];
  logic [7:0]   a_qo[$];
  logic [255:0] b_qd[$];
  logic [7:0]   b_qo[$];
  logic [255:0] c_qd[$];
  logic [7:0]   c_qo[$];

  logic [63:0] fb[3][4];
  int fn[3]    = '{0, 0, 0};
  int fmode[3] = '{0, 0, 0};
  int flen[3]  = '{4, 4, 1};
  int nlane[3] = '{8, 2, 4};
  int accw[3]  = '{32, 8, 16};

  function automatic void ref_frame(input int nl, input int aw, input int n, input int mode,
                                    input logic [63:0] beats[4],
                                    output logic [255:0] d, output logic [7:0] o);
    longint unsigned modv, s, mx, mn, v, r;
    modv = 64'd1 << aw;
    d = '0;
    o = '0;
    for (int l = 0; l < nl; l++) begin
      s = 0; mx = 0; mn = 0;
      for (int b = 0; b < n; b++) begin
        v = (beats[b] >> (l * 8)) & 64'hFF;
        s += v;
        if (b == 0 || v > mx) mx = v;
        if (b == 0 || v < mn) mn = v;
      end
      if (mode == 1) r = mx;
      else if (mode == 2) r = mn;
      else begin
        r = s % modv;
        o[l] = (s >= modv);
      end
      d = d | (256'(r) << (l * aw));
    end
  endfunction

  task automatic model_beat(input int u, input logic [63:0] d, input int m);
    logic [255:0] ed;
    logic [7:0]   eo;
    logic [63:0]  bb[4];
    if (fn[u] == 0) fmode[u] = m;
    fb[u][fn[u]] = d;
    fn[u]++;
    if (fn[u] == flen[u]) begin
      for (int i = 0; i < 4; i++) bb[i] = fb[u][i];
      ref_frame(nlane[u], accw[u], fn[u], fmode[u], bb, ed, eo);
      fn[u] = 0;
      case (u)
        0: begin a_qd.push_back(ed); a_qo.push_back(eo); end
        1: begin b_qd.push_back(ed); b_qo.push_back(eo); end
        default: begin c_qd.push_back(ed); c_qo.push_back(eo); end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input logic [63:0] d, input int m);
    int w = 0;
    a_if.din_vld = 1'b1; a_if.din_data = d; a_if.din_mode = 2'(m);
    @(negedge clk);
    while (a_if.din_busy && w < 100) begin @(negedge clk); w++; end
    chk("a_accept_wait", 256'(a_if.din_busy), 256'(0));
    @(posedge clk); #1;
    a_if.din_vld = 1'b0;
    model_beat(0, d, m);
  endtask

  task automatic drive_b(input logic [15:0] d, input int m);
    int w = 0;
    b_if.din_vld = 1'b1; b_if.din_data = d; b_if.din_mode = 2'(m);
    @(negedge clk);
    while (b_if.din_busy && w < 100) begin @(negedge clk); w++; end
    chk("b_accept_wait", 256'(b_if.din_busy), 256'(0));
    @(posedge clk); #1;
    b_if.din_vld = 1'b0;
    model_beat(1, 64'(d), m);
  endtask

  function automatic logic [63:0] inc_beat(input int b);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(i + b);
    return d;
  endfunction

  function automatic logic [255:0] lanes32(input int base);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i + base);
    return d;
  endfunction

  // ---------------- scoreboard monitors ----------------
  logic [255:0] a_ed, b_ed, c_ed, a_prev;
  logic [7:0]   a_eo, b_eo, c_eo;
  logic         a_prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (a_prev_stall) begin
        chk("a_hold_vld", 256'(a_if.dout_vld), 256'(1));
        chk("a_hold_data", 256'(a_if.dout_data), a_prev);
      end
      if (a_if.dout_vld && !a_if.dout_busy) begin
        if (a_qd.size() == 0) chk("a_unexpected_out", 256'(a_if.dout_vld), 256'(0));
        else begin
          a_ed = a_qd.pop_front(); a_eo = a_qo.pop_front();
          chk("a_dout_data", 256'(a_if.dout_data), a_ed);
          chk("a_dout_ovf", 256'(a_if.dout_ovf), 256'(a_eo));
        end
      end
      a_prev_stall = a_if.dout_vld && a_if.dout_busy;
      a_prev       = 256'(a_if.dout_data);
    end else begin
      a_prev_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst && b_if.dout_vld && !b_if.dout_busy) begin
      if (b_qd.size() == 0) chk("b_unexpected_out", 256'(b_if.dout_vld), 256'(0));
      else begin
        b_ed = b_qd.pop_front(); b_eo = b_qo.pop_front();
        chk("b_dout_data", 256'(b_if.dout_data), b_ed);
        chk("b_dout_ovf", 256'(b_if.dout_ovf), 256'(b_eo));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && c_if.dout_vld && !c_if.dout_busy) begin
      if (c_qd.size() == 0) chk("c_unexpected_out", 256'(c_if.dout_vld), 256'(0));
      else begin
        c_ed = c_qd.pop_front(); c_eo = c_qo.pop_front();
        chk("c_dout_data", 256'(c_if.dout_data), c_ed);
        chk("c_dout_ovf", 256'(c_if.dout_ovf), 256'(c_eo));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0]  d;
    logic [63:0]  d3;
    logic [255:0] hold_exp;
    logic [31:0]  cd;
    int w, n;

    rst = 1'b0;
    a_busy = 1'b0; a_rand_en = 1'b0; b_busy = 1'b0; c_busy = 1'b0;
    a_if.din_vld = 1'b0; a_if.din_data = '0; a_if.din_mode = '0;
    b_if.din_vld = 1'b0; b_if.din_data = '0; b_if.din_mode = '0;
    c_if.din_vld = 1'b0; c_if.din_data = '0; c_if.din_mode = '0;
    idle(3);
    chk("rst_a_vld", 256'(a_if.dout_vld), 256'(0));
    chk("rst_a_data", 256'(a_if.dout_data), 256'(0));
    chk("rst_a_ovf", 256'(a_if.dout_ovf), 256'(0));
    chk("rst_a_busy", 256'(a_if.din_busy), 256'(0));
    chk("rst_a_cnt", 256'(a_dbg_cnt), 256'(0));
    rst = 1'b1;
    idle(1);

    // Sum of all-ones lanes; result visible the cycle after the 4th accept
    for (int b = 0; b < 4; b++) begin
      if (b == 3) chk("a_vld_before_last", 256'(a_if.dout_vld), 256'(0));
      drive_a({8{8'hFF}}, 0);
    end
    chk("a_vld_after_last", 256'(a_if.dout_vld), 256'(1));
    chk("a_sum_ff", 256'(a_if.dout_data), {8{32'h000003FC}});
    chk("a_sum_ff_ovf", 256'(a_if.dout_ovf), 256'(0));
    idle(2);

    // Max then min; mode on later beats must be ignored
    for (int b = 0; b < 4; b++) drive_a(inc_beat(b), (b == 0) ? 1 : 2);
    chk("a_max", 256'(a_if.dout_data), lanes32(3));
    for (int b = 0; b < 4; b++) drive_a(inc_beat(b), (b == 0) ? 2 : 1);
    chk("a_min", 256'(a_if.dout_data), lanes32(0));
    idle(2);

    // Backpressure: frame 1 parked, frame 2 stalls only on its final beat
    a_busy = 1'b1;
    for (int b = 0; b < 4; b++) drive_a({$urandom, $urandom}, 0);
    hold_exp = a_qd[0];
    for (int b = 0; b < 3; b++) drive_a({$urandom, $urandom}, (b == 0) ? 0 : 1);
    chk("a_bp_cnt", 256'(a_dbg_cnt), 256'(3));
    d3 = {$urandom, $urandom};
    a_if.din_vld = 1'b1; a_if.din_data = d3; a_if.din_mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_bp_busy", 256'(a_if.din_busy), 256'(1));
      chk("a_bp_data", 256'(a_if.dout_data), hold_exp);
    end
    @(posedge clk); #1;
    a_busy = 1'b0;
    @(negedge clk);
    chk("a_bp_busy_drain_cycle", 256'(a_if.din_busy), 256'(1));
    @(negedge clk);
    chk("a_bp_busy_released", 256'(a_if.din_busy), 256'(0));
    @(posedge clk); #1;
    a_if.din_vld = 1'b0;
    model_beat(0, d3, 2);
    idle(3);

    // Reset mid-frame
    drive_a({8{8'd1}}, 0);
    drive_a({8{8'd1}}, 0);
    rst = 1'b0; fn[0] = 0;
    idle(1);
    chk("a_rst1_vld", 256'(a_if.dout_vld), 256'(0));
    chk("a_rst1_data", 256'(a_if.dout_data), 256'(0));
    chk("a_rst1_busy", 256'(a_if.din_busy), 256'(0));
    rst = 1'b1;
    for (int b = 0; b < 4; b++) drive_a({8{8'd1}}, 0);
    chk("a_rst1_sum4", 256'(a_if.dout_data), {8{32'd4}});
    idle(2);

    // Reset with a pending result and a partial frame
    a_busy = 1'b1;
    for (int b = 0; b < 4; b++) drive_a({$urandom, $urandom}, 0);
    drive_a({8{8'd1}}, 0);
    drive_a({8{8'd1}}, 0);
    rst = 1'b0; fn[0] = 0; a_qd.delete(); a_qo.delete();
    idle(1);
    chk("a_rst2_vld", 256'(a_if.dout_vld), 256'(0));
    chk("a_rst2_data", 256'(a_if.dout_data), 256'(0));
    chk("a_rst2_ovf", 256'(a_if.dout_ovf), 256'(0));
    chk("a_rst2_busy", 256'(a_if.din_busy), 256'(0));
    rst = 1'b1; a_busy = 1'b0;
    for (int b = 0; b < 4; b++) drive_a({8{8'd1}}, 0);
    chk("a_rst2_sum4", 256'(a_if.dout_data), {8{32'd4}});
    idle(2);

    // Random frames with random consumer stalls and producer gaps
    a_rand_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int b = 0; b < 4; b++) begin
        drive_a({$urandom, $urandom}, $urandom_range(0, 3));
        n = $urandom_range(0, 2);
        if (n == 2) idle(1);
      end
    end
    w = 0;
    while (a_qd.size() != 0 && w < 200) begin @(posedge clk); w++; end
    #1;
    a_rand_en = 1'b0;
    idle(2);

    // 8-bit accumulator wrap
    drive_b({8'd1, 8'd200}, 0);
    drive_b({8'd2, 8'd100}, 0);
    drive_b({8'd3, 8'd0}, 0);
    drive_b({8'd4, 8'd0}, 0);
    chk("b_wrap_data", 256'(b_if.dout_data), 256'(16'h0A2C));
    chk("b_wrap_ovf", 256'(b_if.dout_ovf), 256'(2'b01));
    for (int f = 0; f < 12; f++)
      for (int b = 0; b < 4; b++) drive_b(16'($urandom), $urandom_range(0, 3));
    idle(3);

    // Single-beat frames, continuous producer: accept every other cycle
    cd = $urandom;
    c_if.din_vld = 1'b1; c_if.din_data = cd; c_if.din_mode = 2'($urandom_range(0, 3));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("c_busy_pattern", 256'(c_if.din_busy), 256'(k % 2));
      n = c_if.din_busy;
      @(posedge clk); #1;
      if (n == 0) begin
        model_beat(2, 64'(cd), int'(c_if.din_mode));
        cd = $urandom;
        c_if.din_data = cd;
        c_if.din_mode = 2'($urandom_range(0, 3));
      end
    end
    c_if.din_vld = 1'b0;

    w = 0;
    while ((a_qd.size() + b_qd.size() + c_qd.size()) != 0 && w < 200) begin
      @(posedge clk); w++;
    end
    #1;
    chk("queues_drained", 256'(a_qd.size() + b_qd.size() + c_qd.size()), 256'(0));
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lane_accum_dut.md
# lane_accum_dut

Parametrised multi-lane frame accumulator. It consumes FRAME_LEN input beats of LANES packed unsigned samples over a busy/vld handshake. For each lane it reduces the frame to one ACC_W-bit value using a per-frame mode (sum, max or min), then emits all lanes as one packed word over a busy/vld output handshake. It sits between the stimulus channel and the result sink as the next-generation dut, with a one-deep output holding register so accumulation of frame n+1 overlaps draining of frame n.

## Interface
- LANES, 8, number of parallel lanes
- DATA_W, 8, input sample width per lane
- ACC_W, 32, accumulator/output width per lane; must satisfy ACC_W >= DATA_W
- FRAME_LEN, 4, beats per frame; must be >= 1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- din_busy  out  1  block cannot accept a beat this cycle
- din_vld  in  1  producer presents a beat
- din_data  in  LANES*DATA_W  packed samples, lane i at bits [i*DATA_W +: DATA_W]
- din_mode  in  2  reduction mode, sampled on first beat of a frame only: 0 sum, 1 max, 2 min, 3 reserved (treated as sum)
- dout_busy  in  1  consumer cannot accept
- dout_vld  out  1  output register holds a result
- dout_data  out  LANES*ACC_W  packed results, lane i at bits [i*ACC_W +: ACC_W]
- dout_ovf  out  LANES  per-lane flag, set if a sum wrapped during the frame (0 for max/min)

## Operation
- Transfer on input: din_vld && !din_busy. Transfer on output: dout_vld && !dout_busy.
- State: beat counter cnt (0..FRAME_LEN-1), mode register, LANES accumulators, LANES overflow bits, output register plus out_full.
- FSM: ACCUM (cnt counts beats), no separate idle; the frame start is cnt==0.
- First beat (cnt==0): latch mode. Accumulator loads the zero-extended sample. Overflow clears.
- Later beats:
  - sum: acc += sample modulo 2^ACC_W; ovf |= carry-out.
  - max: acc = max(acc, sample).
  - min: acc = min(acc, sample).
  - Comparisons are unsigned.
- Final beat (cnt==FRAME_LEN-1) accepted: the reduced value including this beat is written to the output register. out_full sets. cnt wraps to 0.
- FRAME_LEN==1: every beat is both first and final; output = zero-extended sample.
- din_busy = (cnt==FRAME_LEN-1) && out_full. Only the final beat can stall. There is no combinational path from dout_busy to din_busy.
- Output drain and a final-beat accept cannot both occur in one cycle, because of the din_busy rule. A drain clears out_full.
- Non-final beats are accepted while out_full=1, so frame n+1 accumulates while frame n waits.
- Reset (rst==0 at an edge):
  - cnt=0, accumulators=0, ovf=0, mode=0, out_full=0.
  - dout_vld=0, dout_data=0, dout_ovf=0, din_busy=0.
  - A mid-frame reset discards the partial frame. A mid-output reset drops the pending result.

## Timing
- Latency: final beat accepted at edge k, then dout_vld=1 after edge k, i.e. in the cycle following acceptance.
- Throughput: one beat per cycle while the consumer drains within FRAME_LEN-1 cycles of dout_vld. For FRAME_LEN==1 and continuous flow, the sustained rate is one beat per 2 cycles.
- dout_data/dout_ovf are stable while dout_vld=1 && dout_busy=1.
- din_busy is a function of registered state only. dout_vld = out_full.
- din_data is ignored when din_vld=0 or din_busy=1.

## Structure
- Shared package lane_accum_pkg:
  - mode enum (MODE_SUM, MODE_MAX, MODE_MIN)
  - default parameter constants
  - a lane-slice helper function
- Sub-module lane_accum_lane: one lane's accumulator, overflow bit, and sum/max/min datapath. It has first/accept/mode inputs and is instantiated LANES times under a generate loop.
- Top level holds cnt, mode register, output register, and handshake logic.

## Test plan
- Sum, all lanes 8'hFF, 4 beats, dout_busy=0:
  - each lane = 32'h000003FC, ovf=0.
  - dout_vld rises the cycle after the 4th accept.
- Max then min on lane i = i+beat (beats 0..3):
  - max frame gives lane i = i+3.
  - following min frame gives lane i = i.
  - mode changed mid-frame is ignored.
- ACC_W=8 sum, lane 0 beats 200,100,0,0:
  - lane 0 = 8'd44, dout_ovf[0]=1; other lanes ovf=0.
- Backpressure: hold dout_busy=1 after frame 1 completes:
  - frame 2 beats 0..2 accepted.
  - din_busy=1 on beat 3 until one cycle after dout_busy drops.
  - frame 1 data held stable; then frame 2 emitted correctly.
- Reset mid-frame after 2 beats, and again with dout_vld=1:
  - all outputs 0 next cycle.
  - next 4 beats of 1 give lane sums of 4, not 6.
- FRAME_LEN=1 back-to-back stream with dout_busy=0:
  - each output equals the zero-extended input.
  - din_busy pattern alternates when a result is pending.
